// File: rtl/stepgen_cfg_sequencer.sv
// AXI4-Lite master that loads the step-generator register bank word by word,
// optionally reading each word back, and reports done or an abort code.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_WR     | AW and W issued together, each dropped on its own handshake
// S_WRESP  | waiting for the write response
// S_RD     | AR issued at the same address as the write
// S_RDATA  | waiting for read data, compared against the written word
// S_NEXT   | one-cycle step to the next word or to S_DONE
// S_DONE   | all words loaded, done high until the next start
// S_ERR    | aborted, error/err_code/err_index high until the next start
module stepgen_cfg_sequencer #(
  parameter int          NUM_REGS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic [NUM_REGS*32-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [3:0]               err_index,
  output logic [31:0]              M_AXI_AWADDR,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [31:0]              M_AXI_WDATA,
  output logic [3:0]               M_AXI_WSTRB,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [31:0]              M_AXI_ARADDR,
  output logic [2:0]               M_AXI_ARPROT,
  output logic                     M_AXI_ARVALID,
  input  logic                     M_AXI_ARREADY,
  input  logic [31:0]              M_AXI_RDATA,
  input  logic [1:0]               M_AXI_RRESP,
  input  logic                     M_AXI_RVALID,
  output logic                     M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        aw_done, aw_done_nxt;
  logic        w_done, w_done_nxt;
  logic [1:0]  err_code_nxt;
  logic [3:0]  err_index_nxt;
  logic [31:0] cur_addr;
  logic [31:0] cur_word;
  logic        aw_hs, w_hs;

  assign cur_addr = BASE_ADDR + {26'd0, idx, 2'b00};

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) cur_word = cfg_data[32*i +: 32];
    end
  end

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

  // AXI outputs decode straight from registered state, so they are glitch-free
  // and fall to zero in the same cycle as an asynchronous reset.
  assign M_AXI_AWVALID = (state == S_WR) && !aw_done;
  assign M_AXI_WVALID  = (state == S_WR) && !w_done;
  assign M_AXI_AWADDR  = (state == S_WR) ? cur_addr : '0;
  assign M_AXI_WDATA   = (state == S_WR) ? cur_word : '0;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_BREADY  = (state == S_WRESP);
  assign M_AXI_ARVALID = (state == S_RD);
  assign M_AXI_ARADDR  = (state == S_RD) ? cur_addr : '0;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state == S_RDATA);

  assign busy  = (state == S_WR) || (state == S_WRESP) || (state == S_RD) ||
                 (state == S_RDATA) || (state == S_NEXT);
  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      idx       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err_code  <= '0;
      err_index <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      aw_done   <= aw_done_nxt;
      w_done    <= w_done_nxt;
      err_code  <= err_code_nxt;
      err_index <= err_index_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    err_code_nxt  = err_code;
    err_index_nxt = err_index;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt     = S_WR;
          idx_nxt       = '0;
          aw_done_nxt   = 1'b0;
          w_done_nxt    = 1'b0;
          err_code_nxt  = 2'b00;
          err_index_nxt = '0;
        end
      end
      S_WR: begin
        if (aw_hs) aw_done_nxt = 1'b1;
        if (w_hs)  w_done_nxt  = 1'b1;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt   = S_WRESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP == 2'b00) begin
            state_nxt = VERIFY ? S_RD : S_NEXT;
          end else begin
            state_nxt     = S_ERR;
            err_code_nxt  = 2'b01;
            err_index_nxt = idx;
          end
        end
      end
      S_RD: begin
        if (M_AXI_ARREADY) state_nxt = S_RDATA;
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            state_nxt     = S_ERR;
            err_code_nxt  = 2'b10;
            err_index_nxt = idx;
          end else if (M_AXI_RDATA != cur_word) begin
            state_nxt     = S_ERR;
            err_code_nxt  = 2'b11;
            err_index_nxt = idx;
          end else begin
            state_nxt = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = S_WR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stepgen_cfg_sequencer.sv
// Bench for stepgen_cfg_sequencer: two instances (verify / write-only) on
// small AXI4-Lite slave models with fault injection, driven from a vector table.
module tb_stepgen_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic [1:0]  start, busy, done, error;
  logic [1:0]  err_code [2];
  logic [3:0]  err_index [2];
  logic [127:0] cfg [2];
  logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
  logic [2:0]  awprot [2], arprot [2];
  logic [3:0]  wstrb [2];
  logic [1:0]  bresp [2], rresp [2];
  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready;

  stepgen_cfg_sequencer #(.NUM_REGS(4), .BASE_ADDR(32'h0000_0000), .VERIFY(1'b1)) u_dut0 (
    .ACLK(clk), .ARESET(arst), .start(start[0]), .cfg_data(cfg[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]),
    .err_code(err_code[0]), .err_index(err_index[0]),
    .M_AXI_AWADDR(awaddr[0]), .M_AXI_AWPROT(awprot[0]), .M_AXI_AWVALID(awvalid[0]),
    .M_AXI_AWREADY(awready[0]), .M_AXI_WDATA(wdata[0]), .M_AXI_WSTRB(wstrb[0]),
    .M_AXI_WVALID(wvalid[0]), .M_AXI_WREADY(wready[0]), .M_AXI_BRESP(bresp[0]),
    .M_AXI_BVALID(bvalid[0]), .M_AXI_BREADY(bready[0]), .M_AXI_ARADDR(araddr[0]),
    .M_AXI_ARPROT(arprot[0]), .M_AXI_ARVALID(arvalid[0]), .M_AXI_ARREADY(arready[0]),
    .M_AXI_RDATA(rdata[0]), .M_AXI_RRESP(rresp[0]), .M_AXI_RVALID(rvalid[0]),
    .M_AXI_RREADY(rready[0])
  );

  stepgen_cfg_sequencer #(.NUM_REGS(4), .BASE_ADDR(32'h0000_0100), .VERIFY(1'b0)) u_dut1 (
    .ACLK(clk), .ARESET(arst), .start(start[1]), .cfg_data(cfg[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]),
    .err_code(err_code[1]), .err_index(err_index[1]),
    .M_AXI_AWADDR(awaddr[1]), .M_AXI_AWPROT(awprot[1]), .M_AXI_AWVALID(awvalid[1]),
    .M_AXI_AWREADY(awready[1]), .M_AXI_WDATA(wdata[1]), .M_AXI_WSTRB(wstrb[1]),
    .M_AXI_WVALID(wvalid[1]), .M_AXI_WREADY(wready[1]), .M_AXI_BRESP(bresp[1]),
    .M_AXI_BVALID(bvalid[1]), .M_AXI_BREADY(bready[1]), .M_AXI_ARADDR(araddr[1]),
    .M_AXI_ARPROT(arprot[1]), .M_AXI_ARVALID(arvalid[1]), .M_AXI_ARREADY(arready[1]),
    .M_AXI_RDATA(rdata[1]), .M_AXI_RRESP(rresp[1]), .M_AXI_RVALID(rvalid[1]),
    .M_AXI_RREADY(rready[1])
  );

  // Slave models: B/R answer one cycle after the request handshake.
  logic [1:0]  aw_got, w_got, have_aw, have_w;
  logic [31:0] aw_q [2], w_q [2], c_addr [2], c_data [2];
  logic [31:0] mem [2][16];
  logic [31:0] aw_log [2][16];
  int          aw_cnt [2], ar_cnt [2], b_cnt [2];
  logic [4:0]  bad_b [2], bad_rr [2], bad_rd [2];

  always_comb begin
    have_aw = '0;
    have_w  = '0;
    for (int s = 0; s < 2; s++) begin
      have_aw[s] = aw_got[s] | (awvalid[s] & awready[s]);
      have_w[s]  = w_got[s] | (wvalid[s] & wready[s]);
      c_addr[s]  = aw_got[s] ? aw_q[s] : awaddr[s];
      c_data[s]  = w_got[s] ? w_q[s] : wdata[s];
    end
  end

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      aw_got <= '0;
      w_got  <= '0;
      bvalid <= '0;
      rvalid <= '0;
      for (int s = 0; s < 2; s++) begin
        aw_cnt[s] <= 0;
        ar_cnt[s] <= 0;
        b_cnt[s]  <= 0;
        bresp[s]  <= 2'b00;
        rresp[s]  <= 2'b00;
        rdata[s]  <= '0;
        aw_q[s]   <= '0;
        w_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (start[s] && !busy[s]) begin
          aw_cnt[s] <= 0;
          ar_cnt[s] <= 0;
          b_cnt[s]  <= 0;
          aw_got[s] <= 1'b0;
          w_got[s]  <= 1'b0;
          for (int k = 0; k < 16; k++) mem[s][k] <= 32'h5A5A_5A5A;
        end else begin
          if (awvalid[s] && awready[s]) begin
            aw_q[s] <= awaddr[s];
            if (aw_cnt[s] < 16) aw_log[s][aw_cnt[s][3:0]] <= awaddr[s];
            aw_cnt[s] <= aw_cnt[s] + 1;
          end
          if (wvalid[s] && wready[s]) w_q[s] <= wdata[s];
          if (have_aw[s] && have_w[s] && !bvalid[s]) begin
            bvalid[s] <= 1'b1;
            bresp[s]  <= ({1'b0, c_addr[s][5:2]} == bad_b[s]) ? 2'b10 : 2'b00;
            mem[s][c_addr[s][5:2]] <= c_data[s];
            aw_got[s] <= 1'b0;
            w_got[s]  <= 1'b0;
          end else begin
            if (awvalid[s] && awready[s]) aw_got[s] <= 1'b1;
            if (wvalid[s] && wready[s])   w_got[s]  <= 1'b1;
          end
          if (bvalid[s] && bready[s]) begin
            bvalid[s] <= 1'b0;
            b_cnt[s]  <= b_cnt[s] + 1;
          end
          if (arvalid[s] && arready[s] && !rvalid[s]) begin
            rvalid[s] <= 1'b1;
            rdata[s]  <= mem[s][araddr[s][5:2]] ^
                         (({1'b0, araddr[s][5:2]} == bad_rd[s]) ? 32'h1 : 32'h0);
            rresp[s]  <= ({1'b0, araddr[s][5:2]} == bad_rr[s]) ? 2'b10 : 2'b00;
            ar_cnt[s] <= ar_cnt[s] + 1;
          end
          if (rvalid[s] && rready[s]) rvalid[s] <= 1'b0;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          inst;
    logic [127:0] cfg;
    logic [4:0]  bb, brr, brd;
    logic        dn, er;
    logic [1:0]  code;
    logic [3:0]  eidx;
    int          cyc, naw, nar, nb;
  } vec_t;

  localparam logic [127:0] CFG1 = {32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
  localparam logic [127:0] CFG2 = {32'h80000001, 32'h12345678, 32'hFFFFFFFF, 32'h00000000};
  localparam logic [4:0]   NONE = 5'd16;

  vec_t        vt [7];
  logic [31:0] base [2];

  task automatic set_faults(input int s, input logic [4:0] b, input logic [4:0] rr, input logic [4:0] rd);
    bad_b[s]  = b;
    bad_rr[s] = rr;
    bad_rd[s] = rd;
  endtask

  task automatic run_vec(input int v);
    int s;
    int cyc;
    logic [127:0] c;
    s = vt[v].inst;
    c = vt[v].cfg;
    @(negedge clk);
    cfg[s] = c;
    set_faults(s, vt[v].bb, vt[v].brr, vt[v].brd);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    chk($sformatf("v%0d busy_after_start", v), {31'd0, busy[s]}, 32'd1);
    cyc = 0;
    while (!(done[s] || error[s]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d cycles", v), cyc, vt[v].cyc);
    chk($sformatf("v%0d done", v), {31'd0, done[s]}, {31'd0, vt[v].dn});
    chk($sformatf("v%0d error", v), {31'd0, error[s]}, {31'd0, vt[v].er});
    chk($sformatf("v%0d err_code", v), {30'd0, err_code[s]}, {30'd0, vt[v].code});
    chk($sformatf("v%0d err_index", v), {28'd0, err_index[s]}, {28'd0, vt[v].eidx});
    chk($sformatf("v%0d busy_end", v), {31'd0, busy[s]}, 32'd0);
    chk($sformatf("v%0d aw_count", v), aw_cnt[s], vt[v].naw);
    chk($sformatf("v%0d ar_count", v), ar_cnt[s], vt[v].nar);
    chk($sformatf("v%0d b_count", v), b_cnt[s], vt[v].nb);
    for (int i = 0; i < vt[v].naw && i < 4; i++) begin
      chk($sformatf("v%0d awaddr%0d", v, i), aw_log[s][i], base[s] + 32'(4 * i));
      chk($sformatf("v%0d mem%0d", v, i), mem[s][i], c[32*i +: 32]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    base[0] = 32'h0000_0000;
    base[1] = 32'h0000_0100;
    vt[0] = '{0, CFG1, NONE, NONE, NONE, 1'b1, 1'b0, 2'b00, 4'd0, 20, 4, 4, 4};
    vt[1] = '{0, CFG1, 5'd2, NONE, NONE, 1'b0, 1'b1, 2'b01, 4'd2, 12, 3, 2, 3};
    vt[2] = '{0, CFG1, NONE, NONE, 5'd1, 1'b0, 1'b1, 2'b11, 4'd1,  9, 2, 2, 2};
    vt[3] = '{1, CFG1, NONE, NONE, NONE, 1'b1, 1'b0, 2'b00, 4'd0, 12, 4, 0, 4};
    vt[4] = '{0, CFG2, NONE, 5'd3, NONE, 1'b0, 1'b1, 2'b10, 4'd3, 19, 4, 4, 4};
    vt[5] = '{1, CFG2, 5'd0, NONE, NONE, 1'b0, 1'b1, 2'b01, 4'd0,  2, 1, 0, 1};
    vt[6] = '{0, CFG2, NONE, NONE, NONE, 1'b1, 1'b0, 2'b00, 4'd0, 20, 4, 4, 4};

    arst    = 1'b1;
    start   = '0;
    awready = 2'b11;
    wready  = 2'b11;
    arready = 2'b11;
    for (int s = 0; s < 2; s++) begin
      cfg[s] = '0;
      set_faults(s, NONE, NONE, NONE);
    end

    #12;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d busy", s), {31'd0, busy[s]}, 32'd0);
      chk($sformatf("rst%0d done", s), {31'd0, done[s]}, 32'd0);
      chk($sformatf("rst%0d error", s), {31'd0, error[s]}, 32'd0);
      chk($sformatf("rst%0d err_code", s), {30'd0, err_code[s]}, 32'd0);
      chk($sformatf("rst%0d err_index", s), {28'd0, err_index[s]}, 32'd0);
      chk($sformatf("rst%0d valids", s), {29'd0, awvalid[s], wvalid[s], arvalid[s]}, 32'd0);
      chk($sformatf("rst%0d readies", s), {30'd0, bready[s], rready[s]}, 32'd0);
      chk($sformatf("rst%0d awaddr", s), awaddr[s], 32'd0);
      chk($sformatf("rst%0d wdata", s), wdata[s], 32'd0);
      chk($sformatf("rst%0d araddr", s), araddr[s], 32'd0);
      chk($sformatf("rst%0d prot_strb", s), {22'd0, awprot[s], arprot[s], wstrb[s]}, 32'h0000_000F);
    end
    @(negedge clk);
    arst = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(v);

    // WREADY well ahead of AWREADY: W completes first, AW must hold.
    @(negedge clk);
    cfg[0] = CFG1;
    set_faults(0, NONE, NONE, NONE);
    awready[0] = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("skew c1 awvalid", {31'd0, awvalid[0]}, 32'd1);
    chk("skew c1 wvalid", {31'd0, wvalid[0]}, 32'd1);
    @(negedge clk);
    chk("skew c2 wvalid", {31'd0, wvalid[0]}, 32'd0);
    chk("skew c2 awvalid", {31'd0, awvalid[0]}, 32'd1);
    chk("skew c2 awaddr", awaddr[0], 32'd0);
    chk("skew c2 bready", {31'd0, bready[0]}, 32'd0);
    @(negedge clk);
    chk("skew c3 awvalid", {31'd0, awvalid[0]}, 32'd1);
    chk("skew c3 awaddr", awaddr[0], 32'd0);
    chk("skew c3 bready", {31'd0, bready[0]}, 32'd0);
    @(negedge clk);
    awready[0] = 1'b1;
    cyc = 3;
    while (!(done[0] || error[0]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("skew cycles", cyc, 23);
    chk("skew done", {31'd0, done[0]}, 32'd1);
    chk("skew error", {31'd0, error[0]}, 32'd0);
    chk("skew aw_count", aw_cnt[0], 4);
    chk("skew mem3", mem[0][3], 32'h0101FFFF);

    // Write-only instance: a start pulse mid-sequence must be ignored.
    @(negedge clk);
    cfg[1] = CFG1;
    set_faults(1, NONE, NONE, NONE);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    start[1] = 1'b1;
    @(negedge clk);
    cyc++;
    start[1] = 1'b0;
    while (!(done[1] || error[1]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("midstart cycles", cyc, 12);
    chk("midstart done", {31'd0, done[1]}, 32'd1);
    chk("midstart aw_count", aw_cnt[1], 4);
    chk("midstart ar_count", ar_cnt[1], 0);
    chk("midstart b_count", b_cnt[1], 4);
    chk("midstart awaddr3", aw_log[1][3], 32'h0000_010C);

    // Reset while AWVALID is high, then a clean restart from word 0.
    @(negedge clk);
    cfg[0] = CFG1;
    awready[0] = 1'b0;
    wready[0]  = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("arst pre awvalid", {31'd0, awvalid[0]}, 32'd1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    chk("arst valids", {29'd0, awvalid[0], wvalid[0], arvalid[0]}, 32'd0);
    chk("arst readies", {30'd0, bready[0], rready[0]}, 32'd0);
    chk("arst busy", {31'd0, busy[0]}, 32'd0);
    chk("arst done_error", {30'd0, done[0], error[0]}, 32'd0);
    chk("arst awaddr", awaddr[0], 32'd0);
    chk("arst inst1 done", {31'd0, done[1]}, 32'd0);
    @(negedge clk);
    arst = 1'b0;
    awready[0] = 1'b1;
    wready[0]  = 1'b1;
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
